// File: rtl/deserializer64_2bit_pkg.sv
// Shared framing definitions for the 2-bit serial shift path.
// Both the serializer and this deserializer derive beat count and counter
// width from the same WIDTH/STEP pair, so the two ends agree on word framing.
package deserializer64_2bit_pkg;

  localparam int WIDTH_DEF = 64;  // assembled word width
  localparam int STEP_DEF  = 2;   // bits moved per transfer

  // Transfers needed to move one word.
  function automatic int beats_of(input int width, input int step);
    return width / step;
  endfunction

  // Width of a counter that spans 0 .. beats-1 (at least one bit).
  function automatic int cnt_width(input int width, input int step);
    return (width / step > 1) ? $clog2(width / step) : 1;
  endfunction

endpackage

// File: rtl/deserializer64_2bit_if.sv
// Handshake bundle for the deserializer.
//   in_valid / in_data / in_ready    : dibit input stage (producer -> block)
//   out_valid / out_data / out_ready : word output stage (block -> consumer)
//   beat_count                       : dibits held in the partial word
// Modports:
//   master : the environment (drives input stage, accepts output stage)
//   slave  : the deserializer itself
interface deserializer64_2bit_if
  import deserializer64_2bit_pkg::*;
  #(
    parameter int WIDTH = WIDTH_DEF,
    parameter int STEP  = STEP_DEF
  );

  localparam int CNT_W = cnt_width(WIDTH, STEP);

  logic             in_valid;
  logic [STEP-1:0]  in_data;
  logic             in_ready;
  logic             out_valid;
  logic [WIDTH-1:0] out_data;
  logic             out_ready;
  logic [CNT_W-1:0] beat_count;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, beat_count
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, beat_count
  );

endinterface

// File: rtl/deserializer64_2bit_shift_reg.sv
// dibit_shift_reg64: left-shifting word register that inserts STEP bits at
// the LSB end on each enabled cycle.
//   clk     : rising-edge clock
//   reset   : synchronous active-high clear
//   en      : shift one lane left and insert din
//   clr     : clear contents (wins over en)
//   din     : serial lane inserted at the LSB end
//   shifted : combinational preview of the register after one shift with din,
//             used by the parent to capture a completed word without an
//             extra cycle
module dibit_shift_reg64
  #(
    parameter int WIDTH = 64,
    parameter int STEP  = 2
  )
  (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             clr,
    input  logic [STEP-1:0]  din,
    output logic [WIDTH-1:0] shifted
  );

  localparam int LANES = WIDTH / STEP;

  logic [WIDTH-1:0] q_reg;

  // Each lane takes the contents of the lane below it; lane 0 takes din.
  for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
    if (gi == 0) begin : g_insert
      assign shifted[STEP-1:0] = din;
    end else begin : g_move
      assign shifted[gi*STEP +: STEP] = q_reg[(gi-1)*STEP +: STEP];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      q_reg <= '0;
    end else if (clr) begin
      q_reg <= '0;
    end else if (en) begin
      q_reg <= shifted;
    end
  end

endmodule

// File: rtl/deserializer64_2bit.sv
// deserializer64_2bit: rebuilds a WIDTH-bit word from a STEP-bit serial
// stream, first beat in the word's top bits, and presents it on a
// valid/ready output stage.
//   clk   : rising-edge clock
//   reset : synchronous active-high reset, overrides en and all handshakes
//   en    : global enable; when low no register changes
//   bus   : handshake bundle (slave side), see deserializer64_2bit_if
module deserializer64_2bit
  import deserializer64_2bit_pkg::*;
  #(
    parameter int WIDTH = WIDTH_DEF,
    parameter int STEP  = STEP_DEF
  )
  (
    input logic                  clk,
    input logic                  reset,
    input logic                  en,
    deserializer64_2bit_if.slave bus
  );

  localparam int BEATS = beats_of(WIDTH, STEP);
  localparam int CNT_W = cnt_width(WIDTH, STEP);

  logic [CNT_W-1:0] beat_cnt_reg, beat_cnt_next;
  logic             out_valid_reg, out_valid_next;
  logic [WIDTH-1:0] out_data_reg, out_data_next;
  logic [WIDTH-1:0] shifted_word;
  logic             last_beat;
  logic             in_ready;
  logic             accept;
  logic             out_fire;

  assign last_beat = (beat_cnt_reg == CNT_W'(BEATS - 1));

  // Only the final beat needs a free output slot; a slot being drained this
  // very cycle counts as free so words can flow without a bubble.
  assign in_ready = ~last_beat | ~out_valid_reg | bus.out_ready;
  assign accept   = en & bus.in_valid & in_ready;
  assign out_fire = en & out_valid_reg & bus.out_ready;

  // The final beat never lands in the shift register: the word goes straight
  // to the output register and the shifter is cleared for the next word.
  dibit_shift_reg64 #(
    .WIDTH (WIDTH),
    .STEP  (STEP)
  ) u_shift (
    .clk     (clk),
    .reset   (reset),
    .en      (accept & ~last_beat),
    .clr     (accept & last_beat),
    .din     (bus.in_data),
    .shifted (shifted_word)
  );

  always_comb begin
    beat_cnt_next  = beat_cnt_reg;
    out_valid_next = out_valid_reg;
    out_data_next  = out_data_reg;

    if (out_fire) begin
      out_valid_next = 1'b0;
    end

    // A new word completing in the same cycle as a drain keeps valid high.
    if (accept) begin
      if (last_beat) begin
        beat_cnt_next  = '0;
        out_data_next  = shifted_word;
        out_valid_next = 1'b1;
      end else begin
        beat_cnt_next = beat_cnt_reg + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      beat_cnt_reg  <= '0;
      out_valid_reg <= 1'b0;
      out_data_reg  <= '0;
    end else begin
      beat_cnt_reg  <= beat_cnt_next;
      out_valid_reg <= out_valid_next;
      out_data_reg  <= out_data_next;
    end
  end

  assign bus.in_ready   = in_ready;
  assign bus.out_valid  = out_valid_reg;
  assign bus.out_data   = out_data_reg;
  assign bus.beat_count = beat_cnt_reg;

endmodule

// File: doc/deserializer64_2bit.md
Name: deserializer64_2bit

Overview:
- Receive end of the 2-bit-per-clock shift path; the counterpart of the 64-bit preset-load / 2-bit-shift serializer.
- Accepts one dibit per accepted cycle and assembles 32 dibits into a 64-bit word, MSB-first.
- Presents the completed word on a valid/ready output stage.
- Sits in the MIPS test datapath wherever a 2-bit serial stream must be rebuilt into a 64-bit operand.

Parameters:
- WIDTH, 64, assembled word width; must be an even multiple of STEP.
- STEP, 2, bits accepted per transfer.
- BEATS, WIDTH/STEP (32), derived (localparam), transfers per word.

Ports:
- Clk  input  1  rising-edge clock.
- Reset  input  1  synchronous, active-high reset.
- En  input  1  global enable; when 0, no state changes (Reset still acts).
- In_Valid  input  1  In_Data holds a valid dibit.
- In_Data  input  STEP  incoming dibit; the first dibit of a word is the word's top bits.
- In_Ready  output  1  block can accept a dibit this cycle.
- Out_Valid  output  1  Out_Data holds a complete word.
- Out_Data  output  WIDTH  assembled word.
- Out_Ready  input  1  consumer accepts Out_Data this cycle.
- Beat_Count  output  log2(BEATS) (5)  number of dibits held in the partial word.

Behaviour:
- Reset (synchronous, Reset=1 at the rising edge): shift register = 0, Beat_Count = 0, Out_Valid = 0, Out_Data = 0. Reset has priority over En and over all handshakes. Reset mid-word discards the partial word and any pending output word.
- Input accept: accept = En & In_Valid & In_Ready.
- Output accept: out_fire = En & Out_Valid & Out_Ready.
- In_Ready (combinational) = (Beat_Count != BEATS-1) | ~Out_Valid | Out_Ready. In_Ready ignores En; no transfer occurs while En=0.
- Accept of a non-final beat:
  - shift register <= {shift[WIDTH-STEP-1:0], In_Data};
  - Beat_Count += 1.
- Accept of the final beat (Beat_Count == BEATS-1):
  - Out_Data <= {shift[WIDTH-STEP-1:0], In_Data};
  - Out_Valid <= 1;
  - Beat_Count <= 0;
  - shift register <= 0.
- Latency: the completed word is visible one cycle after the 32nd accepted beat.
- Throughput: one beat per cycle with no bubble between words, provided the consumer drains each word by the time the next final beat arrives.
- Out_Valid clears on out_fire, unless a final beat is accepted in the same cycle; in that case Out_Valid stays 1 and Out_Data takes the new word.
- While Out_Valid=1 and Out_Ready=0, Out_Data and Out_Valid hold. Beats 0..30 of the next word are still accepted; the final beat stalls via In_Ready=0.
- En=0: all registers hold. A handshake with valid and ready both asserted does not count as a transfer.
- Beat_Count wraps from BEATS-1 to 0 only on the final-beat accept and never exceeds BEATS-1.
- Bit order check: dibit k (0-based) lands at Out_Data[WIDTH-1-2k : WIDTH-2-2k].

Decomposition:
- Shared package (or include file): WIDTH and STEP defaults, plus the BEATS and count-width derivation shared with the serializer, so both ends agree on framing.
- One sub-module: dibit_shift_reg64 (enable, clear, 2-bit left shift with serial insert at LSB).
- The counter, handshake and output register stay in the top level.

Test Plan:
- Reset held 2 cycles, then released:
  - Out_Valid=0, Out_Data=0, Beat_Count=0, In_Ready=1.
- Stream the 32 dibits of 64'h0123456789ABCDEF (MSB dibit first) with Out_Ready=1:
  - one cycle after beat 32, Out_Valid=1 and Out_Data=64'h0123456789ABCDEF;
  - Out_Valid drops the following cycle.
- Back-to-back words 64'hFFFFFFFFFFFFFFFF then 64'h0000000000000003, with Out_Ready=1 and In_Valid continuous:
  - 64 consecutive accepts, no In_Ready deassertion;
  - words appear 32 cycles apart.
- Out_Ready=0 after the first word, keep feeding:
  - beats 1-31 of word 2 are accepted;
  - at Beat_Count=31, In_Ready=0 and Out_Data holds word 1;
  - raise Out_Ready: word 1 retires and the final beat is accepted in the same cycle; next cycle Out_Data=word 2.
- Toggle En=0 for 5 cycles mid-word with In_Valid=1:
  - Beat_Count and shift contents are frozen;
  - the resulting word equals the stall-free result.
- Assert Reset at Beat_Count=17 with Out_Valid=1:
  - next cycle Beat_Count=0, Out_Valid=0;
  - a fresh 32-beat word 64'h8000000000000001 is then assembled correctly.
